// File: rtl/data_cache_wb.sv
// data_cache_wb: write-back engine for the ALU data cache.
// On a write-back request it streams every cache word to DDR through the
// burst-write port of the DDR controller, at the DDR region mapped by the
// cache tag (tag << 3).
// Optional feature macro: DATA_CACHE_WB_SKIP_CLEAN_EN. When it is defined,
// a start with wb_dirty=0 skips the burst and completes immediately.
//
// Handshake with the DDR controller: wr_burst_req is held with a stable
// wr_burst_addr/wr_burst_len until the first wr_burst_data_req. Every
// wr_burst_data_req seen while fewer than DATA_CACHE_DEPTH words have gone
// out reads one cache word. That word appears on wr_burst_data exactly one
// cycle later and is held until the next accepted request. wr_burst_finish
// ends the burst from any active state.
module data_cache_wb #(
    parameter int DATA_CACHE_DEPTH = 16,
    parameter int DATA_WIDTH       = 16,
    parameter int DDR_ADDR_WIDTH   = 28,
    parameter int ADDR_WIDTH_MEM   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_start,
    input  logic [ADDR_WIDTH_MEM-1:0] tag_data,
    input  logic                      wb_dirty,
    output logic                      wb_busy,
    output logic                      wb_done,
    output logic                      cache_rd_en,
    output logic [9:0]                cache_rd_addr,
    input  logic [DATA_WIDTH-1:0]     cache_rd_data,
    output logic                      wr_burst_req,
    output logic [9:0]                wr_burst_len,
    output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                      wr_burst_data_req,
    output logic [DATA_WIDTH-1:0]     wr_burst_data,
    input  logic                      wr_burst_finish,
    output logic [9:0]                data_store_cnt,
    output logic [2:0]                state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_DATA     = 3'd2,
        S_WAIT_FIN = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [9:0] DEPTH = 10'(DATA_CACHE_DEPTH);

    state_t                state;
    state_t                state_nxt;
    logic [9:0]            cnt;
    logic                  word_take;
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] data_hold;
    logic                  skip;

`ifdef DATA_CACHE_WB_SKIP_CLEAN_EN
    // A clean cache has nothing to write back.
    assign skip = ~wb_dirty;
`else
    logic unused_dirty;
    assign unused_dirty = wb_dirty;
    assign skip         = 1'b0;
`endif

    // Next-state logic and detection of an accepted word request.
    always_comb begin
        state_nxt = state;
        word_take = 1'b0;
        case (state)
            S_IDLE: begin
                if (wb_start) state_nxt = skip ? S_DONE : S_REQ;
            end
            S_REQ: begin
                if (wr_burst_data_req) begin
                    word_take = 1'b1;
                    state_nxt = (cnt == DEPTH - 10'd1) ? S_WAIT_FIN : S_DATA;
                end
                if (wr_burst_finish) state_nxt = S_DONE;
            end
            S_DATA: begin
                if (wr_burst_data_req && (cnt < DEPTH)) begin
                    word_take = 1'b1;
                    if (cnt == DEPTH - 10'd1) state_nxt = S_WAIT_FIN;
                end
                // A finish together with the last request still delivers it.
                if (wr_burst_finish) state_nxt = S_DONE;
            end
            S_WAIT_FIN: begin
                if (wr_burst_finish) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Burst descriptor: captured once when a real write-back is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_burst_addr <= '0;
            wr_burst_len  <= '0;
        end else if ((state == S_IDLE) && wb_start && !skip) begin
            wr_burst_addr <= DDR_ADDR_WIDTH'({tag_data, 3'b000});
            wr_burst_len  <= DEPTH;
        end
    end

    // Word counter: saturates at the depth, kept after an early finish,
    // cleared on the way out of DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  cnt <= '0;
        else if (state == S_DONE)  cnt <= '0;
        else if (word_take)        cnt <= cnt + 10'd1;
    end

    // Track the outstanding RAM read and hold the last word sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pending <= 1'b0;
            data_hold  <= '0;
        end else begin
            rd_pending <= word_take;
            data_hold  <= wr_burst_data;
        end
    end

    assign wr_burst_data  = rd_pending ? cache_rd_data : data_hold;
    assign cache_rd_en    = word_take;
    assign cache_rd_addr  = cnt;
    assign data_store_cnt = cnt;
    assign wr_burst_req   = (state == S_REQ);
    assign wb_busy        = (state != S_IDLE);
    assign wb_done        = (state == S_DONE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_data_cache_wb.sv
// Testbench for data_cache_wb: table of burst scenarios, a mid-burst reset
// sequence, and randomized bursts checked against a transaction-level model
// (k-th accepted request yields cache word k one cycle later).
module tb_data_cache_wb;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        wb_start;
    logic [15:0] tag_data;
    logic        wb_dirty;
    logic        wb_busy;
    logic        wb_done;
    logic        cache_rd_en;
    logic [9:0]  cache_rd_addr;
    logic [15:0] cache_rd_data;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [27:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic [15:0] wr_burst_data;
    logic        wr_burst_finish;
    logic [9:0]  data_store_cnt;
    logic [2:0]  state_dbg;

    data_cache_wb dut (
        .clk               (clk),
        .rst               (rst),
        .wb_start          (wb_start),
        .tag_data          (tag_data),
        .wb_dirty          (wb_dirty),
        .wb_busy           (wb_busy),
        .wb_done           (wb_done),
        .cache_rd_en       (cache_rd_en),
        .cache_rd_addr     (cache_rd_addr),
        .cache_rd_data     (cache_rd_data),
        .wr_burst_req      (wr_burst_req),
        .wr_burst_len      (wr_burst_len),
        .wr_burst_addr     (wr_burst_addr),
        .wr_burst_data_req (wr_burst_data_req),
        .wr_burst_data     (wr_burst_data),
        .wr_burst_finish   (wr_burst_finish),
        .data_store_cnt    (data_store_cnt),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Cache RAM model: synchronous read, data one cycle after cache_rd_en.
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (cache_rd_en) cache_rd_data <= mem[cache_rd_addr];
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] exp_data;
    int          delivered;
    int          reqs_seen;
    int          cyc_cnt;
    int          n_checks;
    int          n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    // ---------------- driver tasks ----------------
    // Apply inputs at the falling edge, then sample just after.
    task automatic drive_cycle(input bit start, input logic [15:0] tag, input bit dreq, input bit fin);
        @(negedge clk);
        wb_start          = start;
        tag_data          = tag;
        wr_burst_data_req = dreq;
        wr_burst_finish   = fin;
        cyc_cnt++;
        #1;
        if (exp_q.size() > 0) exp_data = exp_q.pop_front();
    endtask

    task automatic active_cycle(input bit dreq, input bit fin, input bit start2, input logic [27:0] exp_addr);
        bit acc;
        drive_cycle(start2, 16'h0080, dreq, fin);
        acc = dreq && (delivered < DEPTH);
        check("busy", wb_busy, 1);
        check("done_early", wb_done, 0);
        check("burst_req", wr_burst_req, (reqs_seen == 0));
        check("burst_addr", wr_burst_addr, exp_addr);
        check("burst_len", wr_burst_len, DEPTH);
        check("rd_en", cache_rd_en, acc);
        if (acc) check("rd_addr", cache_rd_addr, delivered);
        check("store_cnt", data_store_cnt, delivered);
        check("wr_data", wr_burst_data, exp_data);
        if (dreq) reqs_seen++;
        if (acc) begin
            exp_q.push_back(mem[delivered]);
            delivered++;
        end
    endtask

    task automatic done_cycle(input bit start_in_done, input int exp_cnt, input int exp_lat, input int start_cyc);
        drive_cycle(start_in_done, 16'h0aaa, 0, 0);
        check("done_pulse", wb_done, 1);
        check("busy_done", wb_busy, 1);
        check("cnt_done", data_store_cnt, (exp_cnt < 0) ? delivered : exp_cnt);
        check("req_done", wr_burst_req, 0);
        check("rd_en_done", cache_rd_en, 0);
        check("wr_data_done", wr_burst_data, exp_data);
        if (exp_lat >= 0) check("latency", cyc_cnt - start_cyc, exp_lat);
        drive_cycle(0, 16'h0000, 0, 0);
        check("done_once", wb_done, 0);
        check("busy_off", wb_busy, 0);
        check("cnt_clear", data_store_cnt, 0);
        check("wr_data_hold", wr_burst_data, exp_data);
        delivered = 0;
    endtask

    // One full write-back. gap<0 picks a random gap before each request.
    // fin_idx: request index that carries wr_burst_finish (-1: none).
    task automatic run_burst(input logic [15:0] tag, input int gap, input int n_req, input int fin_idx,
                             input int fin_delay, input int busy_idx, input bit start_in_done,
                             input logic [27:0] exp_addr, input int exp_cnt, input int exp_lat);
        int  start_cyc;
        int  g;
        bit  finished;
`ifdef DATA_CACHE_WB_SKIP_CLEAN_EN
        wb_dirty = 1'b1;
`else
        wb_dirty = 1'($urandom_range(0, 1));
`endif
        drive_cycle(1, tag, 0, 0);
        start_cyc = cyc_cnt;
        check("busy_idle", wb_busy, 0);
        check("done_idle", wb_done, 0);
        check("wr_data_idle", wr_burst_data, exp_data);
        reqs_seen = 0;
        finished  = 1'b0;
        active_cycle(0, 0, 0, exp_addr);
        for (int r = 0; r < n_req; r++) begin
            g = (gap < 0) ? $urandom_range(0, 3) : gap;
            for (int k = 0; k < g; k++) active_cycle(0, 0, 0, exp_addr);
            active_cycle(1, (r == fin_idx), (r == busy_idx), exp_addr);
            if (r == fin_idx) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            for (int k = 0; k < fin_delay; k++) active_cycle(0, 0, 0, exp_addr);
            active_cycle(0, 1, 0, exp_addr);
        end
        done_cycle(start_in_done, exp_cnt, exp_lat, start_cyc);
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [15:0] tag;
        int          gap;
        int          n_req;
        int          fin_idx;
        int          fin_delay;
        int          busy_idx;
        bit          start_in_done;
        logic [27:0] exp_addr;
        int          exp_cnt;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] t;
        int          nr;
        int          fi;
        int          bi;

        // basic ideal burst: done on the 20th cycle counting the start cycle
        vecs[0] = '{16'h0040, 0, 16, -1, 0, -1, 1'b0, 28'h0000200, 16, DEPTH + 3};
        // gapped: request every third cycle, start during DONE ignored
        vecs[1] = '{16'h0041, 2, 16, -1, 2, -1, 1'b1, 28'h0000208, 16, -1};
        // second start with tag 0x0080 mid-burst is ignored
        vecs[2] = '{16'h0040, 0, 16, -1, 0, 5, 1'b0, 28'h0000200, 16, -1};
        // 18 requests, only 16 reads
        vecs[3] = '{16'h0100, 0, 18, -1, 1, -1, 1'b0, 28'h0000800, 16, -1};
        // early finish with the 7th request
        vecs[4] = '{16'h1234, 1, 10, 6, 0, -1, 1'b0, 28'h00091a0, 7, -1};
        // finish together with the final request
        vecs[5] = '{16'hffff, 0, 16, 15, 0, -1, 1'b0, 28'h007fff8, 16, -1};
        // finish while still in the request phase
        vecs[6] = '{16'h0002, 0, 0, -1, 3, -1, 1'b0, 28'h0000010, 0, -1};

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        n_checks          = 0;
        n_pass            = 0;
        cyc_cnt           = 0;
        delivered         = 0;
        reqs_seen         = 0;
        exp_data          = '0;
        rst               = 1'b0;
        wb_start          = 1'b0;
        tag_data          = '0;
        wb_dirty          = 1'b0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;

        // reset state
        @(negedge clk);
        #1;
        check("reset_busy", wb_busy, 0);
        check("reset_done", wb_done, 0);
        check("reset_req", wr_burst_req, 0);
        check("reset_addr", wr_burst_addr, 0);
        check("reset_len", wr_burst_len, 0);
        check("reset_data", wr_burst_data, 0);
        check("reset_cnt", data_store_cnt, 0);
        check("reset_rd_en", cache_rd_en, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i].tag, vecs[i].gap, vecs[i].n_req, vecs[i].fin_idx, vecs[i].fin_delay,
                      vecs[i].busy_idx, vecs[i].start_in_done, vecs[i].exp_addr, vecs[i].exp_cnt,
                      vecs[i].exp_lat);
        end

        // reset after 7 words: everything clears at once, no done pulse
        wb_dirty = 1'b1;
        drive_cycle(1, 16'h0050, 0, 0);
        reqs_seen = 0;
        active_cycle(0, 0, 0, 28'h0000280);
        for (int i = 0; i < 7; i++) active_cycle(1, 0, 0, 28'h0000280);
        @(negedge clk);
        rst               = 1'b0;
        wb_start          = 1'b0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        #1;
        check("midrst_busy", wb_busy, 0);
        check("midrst_done", wb_done, 0);
        check("midrst_req", wr_burst_req, 0);
        check("midrst_addr", wr_burst_addr, 0);
        check("midrst_len", wr_burst_len, 0);
        check("midrst_data", wr_burst_data, 0);
        check("midrst_cnt", data_store_cnt, 0);
        check("midrst_rd_en", cache_rd_en, 0);
        check("midrst_rd_addr", cache_rd_addr, 0);
        exp_q.delete();
        exp_data  = '0;
        delivered = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("midrst_no_done", wb_done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        run_burst(16'h0000, 0, 16, -1, 0, -1, 1'b0, 28'h0000000, 16, DEPTH + 3);

`ifdef DATA_CACHE_WB_SKIP_CLEAN_EN
        // clean cache: straight to done, no burst, no reads
        wb_dirty = 1'b0;
        drive_cycle(1, 16'h0300, 0, 0);
        check("skip_idle", wb_busy, 0);
        drive_cycle(0, 16'h0000, 0, 0);
        check("skip_done", wb_done, 1);
        check("skip_req", wr_burst_req, 0);
        check("skip_rd_en", cache_rd_en, 0);
        drive_cycle(0, 16'h0000, 0, 0);
        check("skip_done_once", wb_done, 0);
        check("skip_busy_off", wb_busy, 0);
`endif

        // randomized bursts
        for (int i = 0; i < 24; i++) begin
            t  = 16'($urandom);
            nr = $urandom_range(0, 20);
            fi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19) : -1;
            bi = $urandom_range(0, 25);
            run_burst(t, -1, nr, fi, $urandom_range(0, 3), bi, 1'($urandom_range(0, 1)),
                      28'({t, 3'b000}), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
